// File: rtl/mfunc_sub_regbank_pkg.sv
// Shared address map, register-select decode and constants for the MFUNC
// sub-block register bank.
package mfunc_regbank_pkg;

    localparam logic [11:0] ADDR_STS_RAW  = 12'h100;
    localparam logic [11:0] ADDR_STS_EVT  = 12'h104;
    localparam logic [11:0] ADDR_IRQ_MASK = 12'h108;
    localparam logic [11:0] ADDR_CMD      = 12'h10C;
    localparam logic [11:0] ADDR_VERSION  = 12'h1FC;

    localparam logic [31:0] VERSION    = 32'h0001_0000;
    localparam logic [31:0] RD_DEFAULT = 32'h0;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CFG,
        SEL_STS_RAW,
        SEL_STS_EVT,
        SEL_IRQ_MASK,
        SEL_CMD,
        SEL_VERSION
    } reg_sel_e;

    // Everything below 0x100 is the config window; the bound on NUM_CFG is
    // applied by the caller, which knows the parameter.
    function automatic reg_sel_e decode_addr(input logic [11:0] word_addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word_addr < ADDR_STS_RAW) begin
            sel = SEL_CFG;
        end else begin
            case (word_addr)
                ADDR_STS_RAW:  sel = SEL_STS_RAW;
                ADDR_STS_EVT:  sel = SEL_STS_EVT;
                ADDR_IRQ_MASK: sel = SEL_IRQ_MASK;
                ADDR_CMD:      sel = SEL_CMD;
                ADDR_VERSION:  sel = SEL_VERSION;
                default:       sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mfunc_sub_regbank_if.sv
// Register access port between the MFUNC address decoder (master) and a
// sub-block register bank (slave).
interface mfunc_sub_regbank_if;

    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [11:0] sub_reg_addr;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;

    modport master (
        output reg_wr_en,
        output reg_rd_en,
        output sub_reg_addr,
        output reg_wr_data,
        input  reg_rd_data,
        input  reg_rd_valid
    );

    modport slave (
        input  reg_wr_en,
        input  reg_rd_en,
        input  sub_reg_addr,
        input  reg_wr_data,
        output reg_rd_data,
        output reg_rd_valid
    );

endinterface

// File: rtl/mfunc_sub_regbank_status_sync.sv
// Multi-stage synchroniser for the asynchronous status levels, plus the
// one-cycle-delayed copy used to detect rising edges.
module mfunc_status_sync #(
    parameter int unsigned NUM_STS     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_STS-1:0] sts_in,
    output logic [NUM_STS-1:0] sts_sync,
    output logic [NUM_STS-1:0] rise
);

    logic [SYNC_STAGES-1:0][NUM_STS-1:0] chain_q;
    logic [NUM_STS-1:0]                  sts_prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q    <= '0;
            sts_prev_q <= '0;
        end else begin
            chain_q    <= {chain_q[SYNC_STAGES-2:0], sts_in};
            sts_prev_q <= chain_q[SYNC_STAGES-1];
        end
    end

    // sts_prev resetting to 0 makes a level that is already high at reset
    // release count as a rise.
    assign sts_sync = chain_q[SYNC_STAGES-1];
    assign rise     = sts_sync & ~sts_prev_q;

endmodule

// File: rtl/mfunc_sub_regbank.sv
// Parametrised MFUNC sub-block register bank: config words, synchronised
// status with sticky W1C events, maskable irq, command pulses, registered reads.
module mfunc_sub_regbank
    import mfunc_regbank_pkg::*;
#(
    parameter int unsigned          NUM_CFG     = 4,
    parameter logic [32*NUM_CFG-1:0] CFG_RST    = {NUM_CFG{32'h0}},
    parameter int unsigned          NUM_STS     = 8,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          NUM_CMD     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mfunc_sub_regbank_if.slave     bus,
    output logic [32*NUM_CFG-1:0]  cfg_out,
    input  logic [NUM_STS-1:0]     sts_in,
    output logic [NUM_CMD-1:0]     cmd_pulse,
    output logic                   irq
);

    logic [11:0]  word_addr;
    reg_sel_e     sel;
    logic [5:0]   cfg_idx;
    logic         cfg_hit;
    logic         wr_cfg;
    logic         wr_evt;
    logic         wr_mask;
    logic         wr_cmd;

    // Byte-lane bits are masked rather than sliced off so the full address
    // bus stays referenced.
    assign word_addr = bus.sub_reg_addr & 12'hFFC;
    assign sel       = decode_addr(word_addr);
    assign cfg_idx   = word_addr[7:2];
    assign cfg_hit   = (sel == SEL_CFG) && (32'(cfg_idx) < NUM_CFG);

    assign wr_cfg  = bus.reg_wr_en && cfg_hit;
    assign wr_evt  = bus.reg_wr_en && (sel == SEL_STS_EVT);
    assign wr_mask = bus.reg_wr_en && (sel == SEL_IRQ_MASK);
    assign wr_cmd  = bus.reg_wr_en && (sel == SEL_CMD);

    // Config words
    logic [NUM_CFG-1:0][31:0] cfg_q;

    // NOTE: each config word is an individual flop with its own reset value,
    // so the whole array is reset here; a RAM-style store would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= CFG_RST;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_cfg && (cfg_idx == 6'(i))) begin
                    cfg_q[i] <= bus.reg_wr_data;
                end
            end
        end
    end

    assign cfg_out = cfg_q;

    // Status, events and interrupt
    logic [NUM_STS-1:0] sts_sync;
    logic [NUM_STS-1:0] rise;
    logic [NUM_STS-1:0] evt_q;
    logic [NUM_STS-1:0] mask_q;
    logic [NUM_STS-1:0] w1c;

    mfunc_status_sync #(
        .NUM_STS     (NUM_STS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_status_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sts_in   (sts_in),
        .sts_sync (sts_sync),
        .rise     (rise)
    );

    assign w1c = wr_evt ? bus.reg_wr_data[NUM_STS-1:0] : '0;

    // A rise in the same cycle as its clear wins: the OR is applied last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q     <= '0;
            mask_q    <= '0;
            irq       <= 1'b0;
            cmd_pulse <= '0;
        end else begin
            evt_q     <= (evt_q & ~w1c) | rise;
            irq       <= |(evt_q & mask_q);
            cmd_pulse <= wr_cmd ? bus.reg_wr_data[NUM_CMD-1:0] : '0;
            if (wr_mask) begin
                mask_q <= bus.reg_wr_data[NUM_STS-1:0];
            end
        end
    end

    // Read path
    logic [31:0] rd_mux;

    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = RD_DEFAULT;
        case (sel)
            SEL_CFG: begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (cfg_idx == 6'(i)) begin
                        rd_mux = cfg_q[i];
                    end
                end
            end
            SEL_STS_RAW:  rd_mux = 32'(sts_sync);
            SEL_STS_EVT:  rd_mux = 32'(evt_q);
            SEL_IRQ_MASK: rd_mux = 32'(mask_q);
            SEL_VERSION:  rd_mux = VERSION;
            default:      rd_mux = RD_DEFAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.reg_rd_data  <= '0;
            bus.reg_rd_valid <= 1'b0;
        end else begin
            bus.reg_rd_valid <= bus.reg_rd_en;
            if (bus.reg_rd_en) begin
                bus.reg_rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_mfunc_sub_regbank.sv
// Self-checking bench for mfunc_sub_regbank: directed scenarios plus a
// randomized register-access phase against a behavioural model.
module tb_mfunc_sub_regbank;

    localparam int NUM_CFG     = 4;
    localparam int NUM_STS     = 8;
    localparam int SYNC_STAGES = 2;
    localparam int NUM_CMD     = 4;
    localparam logic [32*NUM_CFG-1:0] CFG_RST =
        {32'h4444_0004, 32'h0000_0000, 32'h0000_0003, 32'h1111_0000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mfunc_sub_regbank_if bus ();
    logic [32*NUM_CFG-1:0] cfg_out;
    logic [NUM_STS-1:0]    sts_in;
    logic [NUM_CMD-1:0]    cmd_pulse;
    logic                  irq;

    mfunc_sub_regbank #(
        .NUM_CFG     (NUM_CFG),
        .CFG_RST     (CFG_RST),
        .NUM_STS     (NUM_STS),
        .SYNC_STAGES (SYNC_STAGES),
        .NUM_CMD     (NUM_CMD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cfg_out   (cfg_out),
        .sts_in    (sts_in),
        .cmd_pulse (cmd_pulse),
        .irq       (irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the register space
    logic [31:0] cfg_rst_m [NUM_CFG] = '{32'h1111_0000, 32'h0000_0003, 32'h0000_0000, 32'h4444_0004};
    logic [31:0] cfg_m [NUM_CFG];
    logic [7:0]  mask_m;
    logic [7:0]  evt_m;
    logic [7:0]  sts_m;

    logic [11:0] pool [14] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h0FC, 12'h100,
                               12'h104, 12'h108, 12'h10C, 12'h1FC, 12'h200, 12'h110, 12'hFFC};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.reg_wr_en = 1'b0;
        bus.reg_rd_en = 1'b0;
    endtask

    task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
        bus.reg_wr_en    = 1'b1;
        bus.sub_reg_addr = a;
        bus.reg_wr_data  = d;
        tick();
        bus_idle();
    endtask

    task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.reg_rd_en    = 1'b1;
        bus.sub_reg_addr = a;
        tick();
        bus_idle();
        check({tag, "_valid"}, 32'(bus.reg_rd_valid), 32'h1);
        check(tag, bus.reg_rd_data, exp);
    endtask

    task automatic check_cfg_out(input string tag);
        for (int i = 0; i < NUM_CFG; i++) begin
            check($sformatf("%s[%0d]", tag, i), cfg_out[32*i +: 32], cfg_m[i]);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int unsigned w;
        w = int'(a) / 4 * 4;
        if (w < 32'h100) return (w / 4 < NUM_CFG) ? cfg_m[w / 4] : 32'h0;
        case (w)
            32'h100: return {24'h0, sts_m};
            32'h104: return {24'h0, evt_m};
            32'h108: return {24'h0, mask_m};
            32'h1FC: return 32'h0001_0000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        int unsigned w;
        w = int'(a) / 4 * 4;
        if (w < 32'h100 && w / 4 < NUM_CFG) cfg_m[w / 4] = d;
        else if (w == 32'h104) evt_m = evt_m & ~d[7:0];
        else if (w == 32'h108) mask_m = d[7:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] ra, wa;
        logic [31:0] wd, exp_rd, exp_cmd, exp_irq;
        bit          do_rd, do_wr;

        sts_in           = '0;
        bus.reg_wr_en    = 1'b0;
        bus.reg_rd_en    = 1'b0;
        bus.sub_reg_addr = '0;
        bus.reg_wr_data  = '0;
        cfg_m  = cfg_rst_m;
        mask_m = '0;
        evt_m  = '0;
        sts_m  = '0;

        // Reset state
        repeat (3) tick();
        check("rst_rd_valid", 32'(bus.reg_rd_valid), 32'h0);
        check("rst_rd_data", bus.reg_rd_data, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_cmd", 32'(cmd_pulse), 32'h0);
        check_cfg_out("rst_cfg_out");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        read_check("cfg1_rst", 12'h004, 32'h3);
        tick();
        check("rd_valid_drop", 32'(bus.reg_rd_valid), 32'h0);
        check("rd_data_hold", bus.reg_rd_data, 32'h3);
        read_check("sts_raw_rst", 12'h100, 32'h0);
        check("irq_idle", 32'(irq), 32'h0);

        // Same-cycle read and write of one config word
        bus.reg_wr_en    = 1'b1;
        bus.reg_rd_en    = 1'b1;
        bus.sub_reg_addr = 12'h008;
        bus.reg_wr_data  = 32'hA5A5_0001;
        tick();
        bus_idle();
        check("rw_same_old", bus.reg_rd_data, 32'h0);
        cfg_m[2] = 32'hA5A5_0001;
        check_cfg_out("cfg2_out");
        read_check("cfg2_new", 12'h008, 32'hA5A5_0001);

        // Status rise to irq latency, then W1C with input held high
        reg_write(12'h108, 32'h8);
        sts_in[3] = 1'b1;
        for (int c = 1; c <= SYNC_STAGES + 2; c++) begin
            tick();
            check($sformatf("irq_lat_c%0d", c), 32'(irq), (c == SYNC_STAGES + 2) ? 32'h1 : 32'h0);
        end
        read_check("evt_bit3", 12'h104, 32'h8);
        read_check("raw_bit3", 12'h100, 32'h8);
        reg_write(12'h104, 32'h8);
        check("irq_at_clear", 32'(irq), 32'h1);
        tick();
        check("irq_after_clear", 32'(irq), 32'h0);
        read_check("evt_cleared", 12'h104, 32'h0);

        // Clear lands on the edge where bit 0's rise sets: set wins
        sts_in[0] = 1'b1;
        repeat (SYNC_STAGES) tick();
        reg_write(12'h104, 32'h1);
        read_check("evt_set_wins", 12'h104, 32'h1);
        check("irq_masked", 32'(irq), 32'h0);

        // Falling edge leaves events unchanged
        sts_in[3] = 1'b0;
        repeat (4) tick();
        read_check("evt_after_fall", 12'h104, 32'h1);
        read_check("raw_after_fall", 12'h100, 32'h1);

        // Command pulse
        reg_write(12'h10C, 32'h5);
        check("cmd_pulse_on", 32'(cmd_pulse), 32'h5);
        tick();
        check("cmd_pulse_off", 32'(cmd_pulse), 32'h0);
        read_check("cmd_reads_zero", 12'h10C, 32'h0);

        read_check("version", 12'h1FC, 32'h0001_0000);
        read_check("unmapped", 12'h200, 32'h0);
        reg_write(12'h010, 32'hFFFF_FFFF);
        read_check("cfg_oor", 12'h010, 32'h0);
        check_cfg_out("cfg_oor_out");

        // Randomized accesses against the model (status held steady)
        mask_m = 8'h08;
        evt_m  = 8'h01;
        sts_m  = 8'h01;
        for (int it = 0; it < 300; it++) begin
            do_rd = 1'($urandom_range(0, 1));
            do_wr = 1'($urandom_range(0, 1));
            ra = pool[$urandom_range(0, 13)] | 12'($urandom_range(0, 3));
            wa = ($urandom_range(0, 3) == 0) ? ra : (pool[$urandom_range(0, 13)] | 12'($urandom_range(0, 3)));
            wd = $urandom;
            exp_rd  = model_read(ra);
            exp_irq = 32'(|(evt_m & mask_m));
            exp_cmd = (do_wr && (wa & 12'hFFC) == 12'h10C) ? 32'(wd[3:0]) : 32'h0;
            bus.reg_rd_en    = do_rd;
            bus.reg_wr_en    = do_wr;
            bus.sub_reg_addr = do_rd ? ra : wa;
            if (do_rd && do_wr) bus.sub_reg_addr = ra;
            bus.reg_wr_data  = wd;
            if (do_rd && do_wr && wa != ra) begin
                bus.reg_wr_en = 1'b0;
                do_wr = 1'b0;
                exp_cmd = 32'h0;
            end
            if (!do_rd) bus.sub_reg_addr = wa;
            tick();
            bus_idle();
            if (do_wr) model_write(wa, wd);
            if (do_rd) check($sformatf("rnd_rd_%0d_%h", it, ra), bus.reg_rd_data, exp_rd);
            check($sformatf("rnd_valid_%0d", it), 32'(bus.reg_rd_valid), 32'(do_rd));
            check($sformatf("rnd_irq_%0d", it), 32'(irq), exp_irq);
            check($sformatf("rnd_cmd_%0d", it), 32'(cmd_pulse), exp_cmd);
        end
        check_cfg_out("rnd_cfg_out");

        // Build up irq and a command pulse, then reset in the middle of a write
        reg_write(12'h108, 32'hFF);
        sts_in = '0;
        repeat (SYNC_STAGES + 1) tick();
        sts_in = 8'hFF;
        repeat (SYNC_STAGES + 2) tick();
        reg_write(12'h10C, 32'hF);
        check("cmd_pre_rst", 32'(cmd_pulse), 32'hF);
        check("irq_pre_rst", 32'(irq), 32'h1);
        bus.reg_wr_en    = 1'b1;
        bus.sub_reg_addr = 12'h000;
        bus.reg_wr_data  = 32'hFFFF_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        bus_idle();
        cfg_m = cfg_rst_m;
        check_cfg_out("midrst_cfg_out");
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_cmd", 32'(cmd_pulse), 32'h0);
        check("midrst_valid", 32'(bus.reg_rd_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        repeat (SYNC_STAGES + 1) tick();
        read_check("evt_high_at_release", 12'h104, 32'hFF);
        read_check("mask_after_rst", 12'h108, 32'h0);
        read_check("cfg0_after_rst", 12'h000, 32'h1111_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
